// File: rtl/tlc_pkg.sv
// Shared encodings, fault codes and FSM state type for the traffic-light conflict monitor.
package tlc_pkg;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED  = 3'b100;
  localparam light_t LIGHT_YEL  = 3'b010;
  localparam light_t LIGHT_GRN  = 3'b001;
  localparam light_t LIGHT_DARK = 3'b000;

  localparam int NUM_APP = 4;
  localparam int APP_M1  = 0;
  localparam int APP_S   = 1;
  localparam int APP_MT  = 2;
  localparam int APP_M2  = 3;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_ILLEGAL   = 3'd2,
    FC_NO_YEL    = 3'd3,
    FC_SHORT_YEL = 3'd4,
    FC_RED_YEL   = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_MONITOR,
    ST_FAULT
  } state_e;

  function automatic logic light_is_legal(light_t l);
    return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
  endfunction

endpackage

// File: rtl/tlc_conflict_monitor_if.sv
// Controller-side light inputs and lamp-side outputs of the conflict monitor.
interface tlc_conflict_monitor_if;
  import tlc_pkg::*;

  light_t     light_M1_in;
  light_t     light_S_in;
  light_t     light_MT_in;
  light_t     light_M2_in;
  logic       clear_fault;
  light_t     light_M1;
  light_t     light_S;
  light_t     light_MT;
  light_t     light_M2;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output light_M1_in, light_S_in, light_MT_in, light_M2_in, clear_fault,
    input  light_M1, light_S, light_MT, light_M2, fault, fault_code
  );

  modport slave (
    input  light_M1_in, light_S_in, light_MT_in, light_M2_in, clear_fault,
    output light_M1, light_S, light_MT, light_M2, fault, fault_code
  );

endinterface

// File: rtl/tlc_phase_checker.sv
// Per-approach encoding, glitch-run, yellow-duration and transition checks on the
// registered current/previous light values.
module tlc_phase_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YEL    = 3,
  parameter int GLITCH_CYC = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear_i,
  input  logic   first_i,
  input  light_t cur_i,
  input  light_t prev_i,
  output logic   illegal_o,
  output logic   glitch_o,
  output logic   no_yel_o,
  output logic   short_yel_o,
  output logic   red_yel_o
);

  localparam int YW = $clog2(MIN_YEL + 1);
  localparam int GW = $clog2(GLITCH_CYC + 1);

  // yel_cnt_q is the yellow run length ending at prev_i; glitch_cnt_q likewise for illegal values
  logic [YW-1:0] yel_cnt_q, yel_cnt_d;
  logic [GW-1:0] glitch_cnt_q, glitch_cnt_d, glitch_run;

  always_comb begin
    illegal_o  = !light_is_legal(cur_i);
    glitch_run = '0;
    if (illegal_o) begin
      glitch_run = (glitch_cnt_q == GW'(GLITCH_CYC)) ? glitch_cnt_q : glitch_cnt_q + 1'b1;
    end
    glitch_o  = illegal_o && (glitch_run == GW'(GLITCH_CYC));

    yel_cnt_d = '0;
    if (cur_i == LIGHT_YEL) begin
      yel_cnt_d = (yel_cnt_q == YW'(MIN_YEL)) ? yel_cnt_q : yel_cnt_q + 1'b1;
    end
    glitch_cnt_d = glitch_run;
    if (clear_i) begin
      yel_cnt_d    = '0;
      glitch_cnt_d = '0;
    end

    no_yel_o    = !first_i && (prev_i == LIGHT_GRN) && (cur_i == LIGHT_RED);
    short_yel_o = !first_i && (prev_i == LIGHT_YEL) && (cur_i == LIGHT_RED) &&
                  (yel_cnt_q < YW'(MIN_YEL));
    red_yel_o   = !first_i && (prev_i == LIGHT_RED) && (cur_i == LIGHT_YEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yel_cnt_q    <= '0;
      glitch_cnt_q <= '0;
    end else begin
      yel_cnt_q    <= yel_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Conflict monitor: registers controller lights, passes legal safe states to the lamps,
// and latches the first detected fault while flashing all approaches red.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YEL     = 3,
  parameter int GLITCH_CYC  = 2,
  parameter int FLASH_HALF  = 5,
  parameter int STARTUP_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tlc_conflict_monitor_if.slave bus
);

  localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam int FW = $clog2(FLASH_HALF + 1);

  light_t             in_w     [NUM_APP];
  light_t             s_cur_q  [NUM_APP];
  light_t             s_prev_q [NUM_APP];
  light_t             lamp_q   [NUM_APP];
  light_t             lamp_d   [NUM_APP];
  state_e             state_q, state_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic [SW-1:0]      startup_cnt_q, startup_cnt_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;
  logic               first_q;
  logic               clear_ok, conflict, all_red;
  fault_code_e        det_code;
  logic [NUM_APP-1:0] illegal_w, glitch_w, no_yel_w, short_yel_w, red_yel_w;

  assign in_w[APP_M1] = bus.light_M1_in;
  assign in_w[APP_S]  = bus.light_S_in;
  assign in_w[APP_MT] = bus.light_MT_in;
  assign in_w[APP_M2] = bus.light_M2_in;

  for (genvar gi = 0; gi < NUM_APP; gi++) begin : g_chk
    tlc_phase_checker #(
      .MIN_YEL   (MIN_YEL),
      .GLITCH_CYC(GLITCH_CYC)
    ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_ok),
      .first_i    (first_q),
      .cur_i      (s_cur_q[gi]),
      .prev_i     (s_prev_q[gi]),
      .illegal_o  (illegal_w[gi]),
      .glitch_o   (glitch_w[gi]),
      .no_yel_o   (no_yel_w[gi]),
      .short_yel_o(short_yel_w[gi]),
      .red_yel_o  (red_yel_w[gi])
    );
  end

  // Lowest-numbered detection wins when several fire together
  always_comb begin
    conflict = ((s_cur_q[APP_S] != LIGHT_RED) &&
                ((s_cur_q[APP_M1] != LIGHT_RED) || (s_cur_q[APP_M2] != LIGHT_RED) ||
                 (s_cur_q[APP_MT] != LIGHT_RED))) ||
               ((s_cur_q[APP_MT] == LIGHT_GRN) && (s_cur_q[APP_M2] == LIGHT_GRN));
    all_red  = (s_cur_q[APP_M1] == LIGHT_RED) && (s_cur_q[APP_S] == LIGHT_RED) &&
               (s_cur_q[APP_MT] == LIGHT_RED) && (s_cur_q[APP_M2] == LIGHT_RED);
    if (conflict)          det_code = FC_CONFLICT;
    else if (|glitch_w)    det_code = FC_ILLEGAL;
    else if (|no_yel_w)    det_code = FC_NO_YEL;
    else if (|short_yel_w) det_code = FC_SHORT_YEL;
    else if (|red_yel_w)   det_code = FC_RED_YEL;
    else                   det_code = FC_NONE;
  end

  always_comb begin
    state_d       = state_q;
    startup_cnt_d = startup_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    flash_on_d    = flash_on_q;
    fault_d       = fault_q;
    code_d        = code_q;
    clear_ok      = 1'b0;
    for (int i = 0; i < NUM_APP; i++) lamp_d[i] = LIGHT_RED;

    case (state_q)
      ST_STARTUP: begin
        if (startup_cnt_q == SW'(STARTUP_CYC - 1)) state_d = ST_MONITOR;
        else startup_cnt_d = startup_cnt_q + 1'b1;
      end
      ST_MONITOR: begin
        if (det_code != FC_NONE) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = det_code;
          flash_cnt_d = FW'(1);
          flash_on_d  = 1'b1;
        end else begin
          for (int i = 0; i < NUM_APP; i++) lamp_d[i] = illegal_w[i] ? LIGHT_RED : s_cur_q[i];
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault && all_red) begin
          state_d  = ST_MONITOR;
          fault_d  = 1'b0;
          code_d   = FC_NONE;
          clear_ok = 1'b1;
        end else begin
          if (flash_cnt_q == FW'(FLASH_HALF)) begin
            flash_on_d  = !flash_on_q;
            flash_cnt_d = FW'(1);
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          for (int i = 0; i < NUM_APP; i++) lamp_d[i] = flash_on_d ? LIGHT_RED : LIGHT_DARK;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_APP; i++) begin
        s_cur_q[i]  <= LIGHT_RED;
        s_prev_q[i] <= LIGHT_RED;
        lamp_q[i]   <= LIGHT_RED;
      end
      state_q       <= ST_STARTUP;
      fault_q       <= 1'b0;
      code_q        <= FC_NONE;
      startup_cnt_q <= '0;
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_APP; i++) begin
        s_cur_q[i]  <= in_w[i];
        s_prev_q[i] <= s_cur_q[i];
        lamp_q[i]   <= lamp_d[i];
      end
      state_q       <= state_d;
      fault_q       <= fault_d;
      code_q        <= code_d;
      startup_cnt_q <= startup_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_on_q    <= flash_on_d;
      first_q       <= (state_q == ST_STARTUP) && (state_d == ST_MONITOR);
    end
  end

  assign bus.light_M1   = lamp_q[APP_M1];
  assign bus.light_S    = lamp_q[APP_S];
  assign bus.light_MT   = lamp_q[APP_MT];
  assign bus.light_M2   = lamp_q[APP_M2];
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Scoreboard bench: a history-based reference model predicts every output cycle and a
// separate negedge monitor compares the lamp/fault outputs against it.
module tb_tlc_conflict_monitor;

  localparam int MIN_YEL     = 3;
  localparam int GLITCH_CYC  = 2;
  localparam int FLASH_HALF  = 5;
  localparam int STARTUP_CYC = 4;

  localparam logic [2:0]  R     = 3'b100;
  localparam logic [2:0]  Y     = 3'b010;
  localparam logic [2:0]  G     = 3'b001;
  localparam logic [11:0] ALL_R = {R, R, R, R};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] in_m1 = R, in_s = R, in_mt = R, in_m2 = R;
  logic clr = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tlc_conflict_monitor_if bus();

  assign bus.light_M1_in = in_m1;
  assign bus.light_S_in  = in_s;
  assign bus.light_MT_in = in_mt;
  assign bus.light_M2_in = in_m2;
  assign bus.clear_fault = clr;

  tlc_conflict_monitor #(
    .MIN_YEL    (MIN_YEL),
    .GLITCH_CYC (GLITCH_CYC),
    .FLASH_HALF (FLASH_HALF),
    .STARTUP_CYC(STARTUP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist holds every value sampled into the input register, newest last (approach order M1,S,MT,M2)
  logic [11:0] hist [$];
  logic [15:0] expq [$];
  int n, mode, code, fault_edge;

  function automatic logic [2:0] lt(logic [11:0] w, int a);
    return w[(3 - a) * 3 +: 3];
  endfunction

  function automatic bit legal(logic [2:0] v);
    return (v == R) || (v == Y) || (v == G);
  endfunction

  function automatic logic [15:0] outputs_now();
    return {bus.light_M1, bus.light_S, bus.light_MT, bus.light_M2, bus.fault, bus.fault_code};
  endfunction

  function automatic int detect(bit skip_trans);
    logic [11:0] cur, prev;
    int sz, run, yrun;
    bit c1, c2, c3, c4, c5;
    sz   = hist.size();
    cur  = hist[sz - 1];
    prev = hist[sz - 2];
    c1 = ((lt(cur, 1) != R) && ((lt(cur, 0) != R) || (lt(cur, 2) != R) || (lt(cur, 3) != R))) ||
         ((lt(cur, 2) == G) && (lt(cur, 3) == G));
    c2 = 0; c3 = 0; c4 = 0; c5 = 0;
    for (int a = 0; a < 4; a++) begin
      run = 0;
      for (int k = sz - 1; k >= 0 && !legal(lt(hist[k], a)); k--) run++;
      if (run >= GLITCH_CYC) c2 = 1;
      if (!skip_trans) begin
        yrun = 0;
        for (int k = sz - 2; k >= 0 && lt(hist[k], a) == Y; k--) yrun++;
        if (lt(prev, a) == G && lt(cur, a) == R) c3 = 1;
        if (lt(prev, a) == Y && lt(cur, a) == R && yrun < MIN_YEL) c4 = 1;
        if (lt(prev, a) == R && lt(cur, a) == Y) c5 = 1;
      end
    end
    if (c1) return 1;
    if (c2) return 2;
    if (c3) return 3;
    if (c4) return 4;
    if (c5) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    n = 0; mode = 0; code = 0; fault_edge = 0;
    hist.delete();
    hist.push_back(ALL_R);
    hist.push_back(ALL_R);
    expq.delete();
  endtask

  task automatic model_step();
    logic [11:0] cur, lamps;
    logic f;
    int c;
    n++;
    cur   = hist[hist.size() - 1];
    lamps = ALL_R;
    f     = 1'b0;
    if (mode == 0) begin
      if (n == STARTUP_CYC) mode = 1;
    end else if (mode == 1) begin
      c = detect(n == STARTUP_CYC + 1);
      if (c != 0) begin
        mode = 2; code = c; fault_edge = n; f = 1'b1;
      end else begin
        for (int a = 0; a < 4; a++) lamps[(3 - a) * 3 +: 3] = legal(lt(cur, a)) ? lt(cur, a) : R;
      end
    end else begin
      if (clr && cur == ALL_R) begin
        mode = 1; code = 0;
      end else begin
        f = 1'b1;
        lamps = ((((n - fault_edge) / FLASH_HALF) % 2) == 0) ? ALL_R : 12'b0;
      end
    end
    expq.push_back({lamps, f, 3'(code)});
    hist.push_back({in_m1, in_s, in_mt, in_m2});
    if (hist.size() > 64) void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got lamps=%b fault=%b code=%0d, required lamps=%b fault=%b code=%0d",
                  name, $time, act[15:4], act[3], act[2:0], exp[15:4], exp[3], exp[2:0]);
  endtask

  function automatic bit lit(logic [2:0] v);
    return (v == G) || (v == Y);
  endfunction

  initial begin
    logic [15:0] exp_v, act_v;
    bit unsafe;
    forever begin
      @(negedge clk);
      if (!rst && expq.size() > 0) begin
        exp_v = expq.pop_front();
        act_v = outputs_now();
        check("cycle", act_v, exp_v);
        unsafe = (lit(bus.light_S) && (lit(bus.light_M1) || lit(bus.light_MT) || lit(bus.light_M2))) ||
                 (bus.light_MT == G && bus.light_M2 == G);
        total_cnt++;
        if (!unsafe) pass_cnt++;
        else $display("FAIL safety @%0t: got conflicting lamps %b, required non-conflicting",
                      $time, act_v[15:4]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] m1, s, mt, m2, input logic c, input int cycles);
    $display("drive M1=%b S=%b MT=%b M2=%b clr=%b x%0d", m1, s, mt, m2, c, cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_m1 = m1; in_s = s; in_mt = mt; in_m2 = m2; clr = c;
    end
  endtask

  task automatic clear_seq();
    drive(R, R, R, R, 1'b0, 3);
    drive(R, R, R, R, 1'b1, 1);
    drive(R, R, R, R, 1'b0, 3);
  endtask

  function automatic logic [2:0] rnd_light();
    int r;
    r = $urandom_range(0, 15);
    if (r < 8)  return R;
    if (r < 11) return G;
    if (r < 14) return Y;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] a, b, c, d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_state", outputs_now(), {ALL_R, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;

    drive(R, R, R, R, 1'b0, 10);

    drive(G, R, R, G, 1'b0, 10);
    drive(Y, R, R, Y, 1'b0, 3);
    drive(R, R, R, R, 1'b0, 6);

    drive(R, R, 3'b011, R, 1'b0, 1);
    drive(R, R, R, R, 1'b0, 4);
    drive(R, R, 3'b011, R, 1'b0, 2);
    drive(R, R, R, R, 1'b0, 4);
    clear_seq();

    drive(R, R, R, G, 1'b0, 3);
    drive(R, R, R, Y, 1'b0, 2);
    drive(R, R, R, R, 1'b0, 3);
    drive(R, G, R, R, 1'b0, 1);
    drive(R, G, R, R, 1'b1, 1);
    drive(R, R, R, R, 1'b0, 2);
    clear_seq();
    drive(R, R, R, G, 1'b0, 4);
    drive(R, R, R, Y, 1'b0, 3);
    drive(R, R, R, R, 1'b0, 3);

    drive(G, G, R, R, 1'b0, 1);
    drive(R, R, R, R, 1'b0, 25);
    clear_seq();

    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        clear_seq();
      end else begin
        for (int k = 0; k < 8; k++) begin
          a = rnd_light(); b = rnd_light(); c = rnd_light(); d = rnd_light();
          drive(a, b, c, d, ($urandom_range(0, 7) == 0), 1);
        end
      end
    end
    clear_seq();

    drive(G, G, R, R, 1'b0, 1);
    drive(R, R, R, R, 1'b0, 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async", outputs_now(), {ALL_R, 1'b0, 3'd0});
    drive(G, R, R, R, 1'b0, 2);
    check("reset_held", outputs_now(), {ALL_R, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    drive(G, R, R, R, 1'b0, 2);
    drive(R, R, R, R, 1'b0, 12);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
